// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: per-stage control pair,
// forwarding selector, MULT/DIV sequencer states and the register match helper.
package hazard_ctrl_pkg;

    typedef logic [4:0] creg_addr_t;

    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctrl_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_M  = 2'b01,
        FWD_W  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam int CNT_W = 6;

    // A later-stage writer matches a decode source only if the source is read,
    // the writer really writes, and the register is not $zero.
    function automatic logic reg_match(input creg_addr_t addr, input logic used,
                                       input logic wen, input creg_addr_t dst);
        return used & wen & (dst != 5'd0) & (addr == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_muldiv_seq.sv
// MULT/DIV exec-stage occupancy sequencer: holds the exec stage for the
// configured latency and pulses md_done on the release cycle.
module muldiv_seq
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic mdstart,
    input  logic isdiv,
    input  logic mem_wait,
    input  logic exc,
    output logic md_busy,
    output logic md_done
);

    // A latency of one never needs the BUSY state.
    localparam logic MUL_MULTI = (MUL_LAT > 1);
    localparam logic DIV_MULTI = (DIV_LAT > 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);

    md_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             busy, done;

    // State and counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state, counter load/decrement and busy/done decode.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            MD_IDLE: begin
                if (mdstart && (isdiv ? DIV_MULTI : MUL_MULTI) && !exc) begin
                    busy    = 1'b1;
                    state_n = MD_BUSY;
                    cnt_n   = isdiv ? DIV_LOAD : MUL_LOAD;
                end
            end
            MD_BUSY: begin
                if (exc) begin
                    state_n = MD_IDLE;
                    cnt_n   = '0;
                end else if (cnt != '0) begin
                    busy  = 1'b1;
                    cnt_n = cnt - CNT_W'(1);
                end else if (mem_wait) begin
                    busy = 1'b1;
                end else begin
                    done    = 1'b1;
                    state_n = MD_IDLE;
                end
            end
            default: state_n = MD_IDLE;
        endcase
    end

    assign md_busy = busy & ~reset;
    assign md_done = done & ~reset;

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Build option: define HAZARD_FORWARD_EN to resolve RAW hazards from the M/W
// stages by forwarding; otherwise every RAW hazard stalls decode.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ra1D,
    input  logic [4:0] ra2D,
    input  logic       use1D,
    input  logic       use2D,
    input  logic [4:0] dstE,
    input  logic       wenE,
    input  logic       memreadE,
    input  logic [4:0] dstM,
    input  logic       wenM,
    input  logic       memreadM,
    input  logic [4:0] dstW,
    input  logic       wenW,
    input  logic       mdstartE,
    input  logic       isdivE,
    input  logic       i_wait,
    input  logic       d_wait,
    input  logic       excM,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       flushW,
    output logic [1:0] fwdA,
    output logic [1:0] fwdB,
    output logic       md_busy,
    output logic       md_done
);

    logic        mem_wait;
    logic        e1, e2, m1, m2, w1, w2;
    logic        raw_stall;
    fwd_sel_t    fwd_a, fwd_b;
    stage_ctrl_t ctl_d, ctl_e, ctl_m;
    logic        stall_f, flush_w;
    logic        unused;

    assign mem_wait = d_wait | i_wait;

    // A load in E is caught by the plain E match; memreadE needs no extra term.
    assign unused = memreadE ^ memreadM;

    muldiv_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_seq (
        .clk      (clk),
        .reset    (reset),
        .mdstart  (mdstartE),
        .isdiv    (isdivE),
        .mem_wait (mem_wait),
        .exc      (excM),
        .md_busy  (md_busy),
        .md_done  (md_done)
    );

    assign e1 = reg_match(ra1D, use1D, wenE, dstE);
    assign e2 = reg_match(ra2D, use2D, wenE, dstE);
    assign m1 = reg_match(ra1D, use1D, wenM, dstM);
    assign m2 = reg_match(ra2D, use2D, wenM, dstM);
    assign w1 = reg_match(ra1D, use1D, wenW, dstW);
    assign w2 = reg_match(ra2D, use2D, wenW, dstW);

    // RAW hazard detection and decode operand source selection.
    always_comb begin
`ifdef HAZARD_FORWARD_EN
        raw_stall = e1 | e2 | (memreadM & (m1 | m2));
        fwd_a     = m1 ? FWD_M : (w1 ? FWD_W : FWD_RF);
        fwd_b     = m2 ? FWD_M : (w2 ? FWD_W : FWD_RF);
`else
        raw_stall = e1 | e2 | m1 | m2 | w1 | w2;
        fwd_a     = FWD_RF;
        fwd_b     = FWD_RF;
`endif
    end

    // Stall/flush priority: exception, memory wait, MULT/DIV hold, RAW stall.
    always_comb begin
        stall_f = 1'b0;
        ctl_d   = '0;
        ctl_e   = '0;
        ctl_m   = '0;
        flush_w = 1'b0;
        if (reset) begin
            ctl_d.flush = 1'b1;
            ctl_e.flush = 1'b1;
            ctl_m.flush = 1'b1;
            flush_w     = 1'b1;
        end else if (excM) begin
            ctl_d.flush = 1'b1;
            ctl_e.flush = 1'b1;
            ctl_m.flush = 1'b1;
        end else if (mem_wait) begin
            stall_f     = 1'b1;
            ctl_d.stall = 1'b1;
            ctl_e.stall = 1'b1;
            ctl_m.stall = 1'b1;
            flush_w     = 1'b1;
        end else if (md_busy) begin
            stall_f     = 1'b1;
            ctl_d.stall = 1'b1;
            ctl_e.stall = 1'b1;
            ctl_m.flush = 1'b1;
        end else if (raw_stall) begin
            stall_f     = 1'b1;
            ctl_d.stall = 1'b1;
            ctl_e.flush = 1'b1;
        end
    end

    assign stallF = stall_f;
    assign stallD = ctl_d.stall;
    assign stallE = ctl_e.stall;
    assign stallM = ctl_m.stall;
    assign flushD = ctl_d.flush;
    assign flushE = ctl_e.flush;
    assign flushM = ctl_m.flush;
    assign flushW = flush_w;
    assign fwdA   = reset ? 2'b00 : fwd_a;
    assign fwdB   = reset ? 2'b00 : fwd_b;

endmodule
